pll_clk_sequencer: RTL and testbench
====================================

Name: pll_clk_sequencer

Overview:
- Post-PLL clock-enable generator for GW1NZ designs; runs in the rPLL output domain.
- Qualifies the PLL lock signal and holds off all downstream timing until lock is stable.
- Generates NUM_CH phase-aligned clock-enable strobes and divided square waves, each with a runtime-programmable divisor.
- Divisor updates are applied glitch-free at channel wrap; lock loss is flagged and all outputs are stopped.

Parameters:
- NUM_CH, 2: number of output channels (1..8).
- DIV_W, 8: divisor width in bits.
- DEFAULT_DIV, 2: divisor loaded into every channel at reset.
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required before RUN (>=2).
- SYNC_STAGES, 2: synchroniser depth for pll_lock (>=2).

Ports:
- clkin  in  1  PLL output clock; only clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  rPLL LOCK, asynchronous to clkin.
- cfg_valid  in  1  divisor update request.
- cfg_ready  out  1  update slot free.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  DIV_W  new divisor; 0 is treated as 1.
- lock_clr  in  1  clears lock_lost.
- ready  out  1  high in RUN.
- lock_lost  out  1  sticky: lock dropped while in RUN.
- ce  out  NUM_CH  one-cycle enable strobe per channel.
- clkdiv  out  NUM_CH  divided square wave per channel (registered, fabric use only).

Behaviour:
- Reset (asynchronous assert, synchronous release in effect):
  - ready=0, lock_lost=0, ce=0, clkdiv=0, cfg_ready=1.
  - State = WAIT_LOCK; all divisors = DEFAULT_DIV; all counters and synchroniser stages = 0.
- Synchroniser: pll_lock passes through SYNC_STAGES flops to give lock_s.
- State machine:
  - WAIT_LOCK: lock_s=1 -> QUALIFY with qualification count = 0.
  - QUALIFY: count increments each cycle.
    - lock_s=0 -> WAIT_LOCK.
    - count = LOCK_CYCLES-1 with lock_s=1 -> RUN; every channel counter is set to 0 on the same edge, so all channels start phase-aligned.
  - RUN: ready=1.
    - lock_s=0 -> WAIT_LOCK and lock_lost<=1 on the same edge.
    - ready, ce and clkdiv are 0 from the next cycle.
- Latency: ready rises exactly SYNC_STAGES+LOCK_CYCLES+1 edges after the first edge that samples pll_lock=1, given pll_lock stays high.
- Channel k, divisor D (D=0 treated as 1):
  - Counter cnt runs 0..D-1 and wraps to 0; it runs only in RUN.
  - ce[k]=1 in the cycle where cnt=D-1 (registered), giving one pulse every D cycles. D=1 gives ce constantly high.
  - clkdiv[k]=1 while cnt<ceil(D/2), else 0. Odd D gives the longer high phase; D=1 gives a constant 1.
  - Outside RUN, ce[k]=0 and clkdiv[k]=0.
- Config handshake (single pending slot):
  - Transfer occurs when cfg_valid & cfg_ready; cfg_ready drops on the next edge.
  - Outside RUN: the pending value is written to its divisor on the next edge; cfg_ready returns 1 the cycle after that.
  - In RUN: the value is written on the edge where the target cnt wraps D-1 -> 0, and the new D governs from cnt=0. The old period always completes, so there are no runt pulses. cfg_ready returns 1 on the same edge as the write.
  - cfg_ch >= NUM_CH: transfer accepted and the value discarded; cfg_ready returns 1 next cycle.
  - Lock lost with an update pending: the update is applied on the next edge; the slot is never lost.
- lock_lost:
  - Cleared by lock_clr=1 on the next edge.
  - A simultaneous set and clear gives set.
  - Unaffected by re-lock.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); a pending config is discarded.
- Divisor arithmetic: unsigned, DIV_W bits; the maximum period is 2^DIV_W-1 cycles.

Test Plan:
- Lock qualification (SYNC_STAGES=2, LOCK_CYCLES=16): pll_lock 0->1 and held -> ready=1 exactly 19 edges later. ce[0] (D=2) is first asserted 2 cycles after ready; ce[0] and ce[1] (both D=2) coincide.
- Lock glitch: pll_lock high for 10 cycles, low 1, high again -> state returns to WAIT_LOCK. ready rises 19 edges after the second rise; lock_lost stays 0.
- Divisor change in RUN: ch0 D=4 running; write D=3 mid-period -> current 4-cycle period completes, then ce period = 3 and clkdiv = 110 pattern. cfg_ready stays low until the wrap.
- Edge divisors: D=0 and D=1 -> ce constantly 1 and clkdiv constantly 1. D=255 -> ce period 255 and clkdiv high 128 / low 127.
- Lock loss: in RUN, drop pll_lock -> ready, ce and clkdiv all 0 by edge SYNC_STAGES+2 after the drop; lock_lost=1 and stays set through re-lock until lock_clr; simultaneous set and lock_clr yields 1.
- Async reset mid-RUN with a config pending: rst_n=0 -> all outputs 0 and cfg_ready=1 immediately. After release, the divisors equal DEFAULT_DIV and the pending value is gone.

Source files
------------

// File: rtl/pll_clk_sequencer.sv
// Post-PLL clock-enable sequencer: qualifies rPLL lock, then drives NUM_CH
// phase-aligned enable strobes / divided square waves with glitch-free divisor updates.

module pll_clk_sequencer_ch #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             run,
  input  logic             run_nxt,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             wrap,
  output logic             ce,
  output logic             clkdiv
);
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, deff;
  logic [DIV_W:0]   half;
  logic             ce_q, ce_d, clkdiv_q, clkdiv_d, go;

  always_comb begin
    deff     = (div_q == '0) ? DIV_W'(1) : div_q;
    half     = ({1'b0, deff} + (DIV_W+1)'(1)) >> 1;
    go       = run & run_nxt;
    wrap     = run & (cnt_q >= deff - DIV_W'(1));
    // Outputs are the registered image of the current count; leaving RUN zeroes them at once.
    cnt_d    = (go && !wrap) ? cnt_q + DIV_W'(1) : '0;
    ce_d     = go & wrap;
    clkdiv_d = go & ({1'b0, cnt_q} < half);
    div_d    = wr_en ? wr_div : div_q;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DIV_W'(DEFAULT_DIV);
      cnt_q    <= '0;
      ce_q     <= 1'b0;
      clkdiv_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
      clkdiv_q <= clkdiv_d;
    end
  end

  assign ce     = ce_q;
  assign clkdiv = clkdiv_q;
endmodule

module pll_clk_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              lock_clr,
  output logic              ready,
  output logic              lock_lost,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clkdiv
);
  localparam int QW = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, RUN} state_t;
  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
  } cfg_req_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   pend_vld_q, pend_vld_d;
  cfg_req_t               pend_q, pend_d;
  logic [NUM_CH-1:0]      wrap, wr_en;
  logic                   lock_s, run, run_nxt, pend_bad;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign run       = (state_q == RUN);
  assign run_nxt   = (state_d == RUN);
  assign ready     = run;
  assign lock_lost = lock_lost_q;
  assign cfg_ready = ~pend_vld_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pll_lock};
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    lock_lost_d = lock_lost_q;
    unique case (state_q)
      WAIT_LOCK: if (lock_s) begin
        state_d = QUALIFY;
        qcnt_d  = '0;
      end
      QUALIFY: begin
        qcnt_d = qcnt_q + QW'(1);
        if (!lock_s)                                state_d = WAIT_LOCK;
        else if (qcnt_q == QW'(LOCK_CYCLES - 1))    state_d = RUN;
      end
      RUN:     if (!lock_s) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
    // Set has priority over a simultaneous clear.
    if (lock_clr)         lock_lost_d = 1'b0;
    if (run && !lock_s)   lock_lost_d = 1'b1;
  end

  always_comb begin
    pend_bad   = ({1'b0, pend_q.ch} >= (CH_W+1)'(NUM_CH));
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (cfg_valid && cfg_ready) begin
      pend_vld_d = 1'b1;
      pend_d     = '{ch: cfg_ch, div: cfg_div};
    end else if (pend_vld_q && (pend_bad || (|wr_en))) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      sync_q      <= '0;
      qcnt_q      <= '0;
      lock_lost_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      qcnt_q      <= qcnt_d;
      lock_lost_q <= lock_lost_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
    end
  end

  // In RUN a channel only takes a new divisor as its period wraps, so no runt pulses.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wr_en[k] = pend_vld_q & (pend_q.ch == CH_W'(k)) & (~run | wrap[k]);
    pll_clk_sequencer_ch #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clkin   (clkin),
      .rst_n   (rst_n),
      .run     (run),
      .run_nxt (run_nxt),
      .wr_en   (wr_en[k]),
      .wr_div  (pend_q.div),
      .wrap    (wrap[k]),
      .ce      (ce[k]),
      .clkdiv  (clkdiv[k])
    );
  end
endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Directed bench for pll_clk_sequencer: a phase/period model checked every cycle
// plus literal expectations for lock latency, divisor patterns and lock-loss handling.

module tb_pll_clk_sequencer;
  localparam int NUM_CH = 2, DIV_W = 8, DEFAULT_DIV = 2, LOCK_CYCLES = 16, SYNC_STAGES = 2;
  localparam int CH_W = 1;

  logic              clkin = 1'b0, rst_n = 1'b1, pll_lock = 1'b0;
  logic              cfg_valid = 1'b0, lock_clr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_ready, ready, lock_lost;
  logic [NUM_CH-1:0] ce, clkdiv;

  int n_checks = 0, n_errors = 0;

  pll_clk_sequencer #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV),
    .LOCK_CYCLES(LOCK_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .lock_clr(lock_clr), .ready(ready), .lock_lost(lock_lost),
    .ce(ce), .clkdiv(clkdiv)
  );

  always #5 clkin = ~clkin;

  // Model: lock history, streak of qualified cycles, per-channel phase within period.
  bit m_sync [SYNC_STAGES];
  int m_streak, m_pch, m_pdiv;
  bit m_run, m_lost, m_pend;
  int m_div [NUM_CH];
  int m_pos [NUM_CH];
  bit m_ce  [NUM_CH];
  bit m_ck  [NUM_CH];

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_sync[i]) m_sync[i] = 1'b0;
    m_streak = 0; m_run = 0; m_lost = 0; m_pend = 0; m_pch = 0; m_pdiv = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_div[k] = DEFAULT_DIV; m_pos[k] = 0; m_ce[k] = 0; m_ck[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit ls, nrun, stay, pend_pre, done;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls = m_sync[SYNC_STAGES-1];
    for (int i = SYNC_STAGES-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = pll_lock;
    // RUN is entered on the (LOCK_CYCLES+1)-th consecutive edge that sees synchronised lock.
    if (m_run) nrun = ls;
    else begin
      m_streak = ls ? m_streak + 1 : 0;
      nrun = (m_streak == LOCK_CYCLES + 1);
    end
    stay     = m_run && nrun;
    pend_pre = m_pend;
    done     = (m_pend && m_pch >= NUM_CH);
    for (int k = 0; k < NUM_CH; k++) begin
      bit at_end;
      d = eff(m_div[k]);
      at_end  = (m_pos[k] == d - 1);
      m_ce[k] = stay && at_end;
      m_ck[k] = stay && (2 * m_pos[k] < d);
      if (pend_pre && m_pch == k && (!m_run || at_end)) begin
        m_div[k] = m_pdiv;
        done = 1;
      end
      m_pos[k] = stay ? (m_pos[k] + 1) % d : 0;
    end
    if (m_run && !ls)  m_lost = 1;
    else if (lock_clr) m_lost = 0;
    if (m_run && !nrun) m_streak = 0;
    if (done) m_pend = 0;
    if (cfg_valid && !pend_pre) begin
      m_pend = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div);
    end
    m_run = nrun;
  endtask

  task automatic compare_all();
    chk("ready", ready, m_run);
    chk("lock_lost", lock_lost, m_lost);
    chk("cfg_ready", cfg_ready, !m_pend);
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("ce[%0d]", k), ce[k], m_ce[k]);
      chk($sformatf("clkdiv[%0d]", k), clkdiv[k], m_ck[k]);
    end
  endtask

  task automatic cyc();
    @(posedge clkin);
    model_edge();
    #1;
    compare_all();
    @(negedge clkin);
  endtask

  task automatic cfg_write(input int ch, input int dv);
    cfg_ch = CH_W'(ch); cfg_div = DIV_W'(dv); cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_cfg_ready(input string nm);
    for (int i = 0; i < 300 && !cfg_ready; i++) cyc();
    chk(nm, cfg_ready, 1);
  endtask

  task automatic wait_ce0(input int bound, input string nm);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      cyc();
      found = ce[0];
    end
    chk(nm, found, 1);
  endtask

  initial begin
    logic [8:0] sce, sck;
    logic [2:0] srdy;
    logic       ok;
    int         per, hi;

    model_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_ce", ce, 0);
    chk("rst_clkdiv", clkdiv, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(negedge clkin);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Lock qualification: ready 19 edges after the first edge that samples lock.
    pll_lock = 1'b1;
    repeat (18) cyc();
    chk("lock_lat_pre", ready, 0);
    cyc(); chk("lock_lat", ready, 1);
    cyc(); chk("ce_first_pre", ce, 2'b00); chk("clkdiv_first", clkdiv, 2'b11);
    cyc(); chk("ce_first", ce, 2'b11);     chk("clkdiv_second", clkdiv, 2'b00);

    // Divisor change mid-period: 4 -> 3 waits for the 4-cycle period to finish.
    cfg_write(0, 4);
    wait_cfg_ready("w_d4");
    repeat (6) cyc();
    wait_ce0(20, "d4_sync");
    cyc();
    cfg_ch = '0; cfg_div = 8'd3; cfg_valid = 1'b1;
    sce = '0; sck = '0; srdy = '0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      cfg_valid = 1'b0;
      sce = {sce[7:0], ce[0]};
      sck = {sck[7:0], clkdiv[0]};
      if (i < 3) srdy = {srdy[1:0], cfg_ready};
    end
    chk("d3_ce_seq", sce, 9'b001001001);
    chk("d3_ck_seq", sck, 9'b100110110);
    chk("d3_cfg_ready_seq", srdy, 3'b001);

    // Edge divisors on ch1: 0 and 1 both mean constant high.
    cfg_write(1, 0);
    wait_cfg_ready("w_d0");
    repeat (3) cyc();
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin cyc(); ok = ok & ce[1] & clkdiv[1]; end
    chk("d0_const", ok, 1);
    cfg_write(1, 1);
    wait_cfg_ready("w_d1");
    repeat (2) cyc();
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin cyc(); ok = ok & ce[1] & clkdiv[1]; end
    chk("d1_const", ok, 1);

    // Maximum divisor on ch0.
    cfg_write(0, 255);
    wait_cfg_ready("w_d255");
    wait_ce0(300, "d255_sync");
    per = 0; hi = 0;
    do begin
      cyc();
      per++;
      hi += int'(clkdiv[0]);
    end while (!ce[0] && per < 300);
    chk("d255_period", per, 255);
    chk("d255_high", hi, 128);
    chk("d255_low", per - hi, 127);

    // Lock loss, sticky flag through re-lock, clear, then set-vs-clear priority.
    pll_lock = 1'b0;
    cyc(); cyc(); chk("loss_ready_hold", ready, 1);
    cyc();
    chk("loss_ready", ready, 0);
    chk("loss_flag", lock_lost, 1);
    chk("loss_ce", ce, 0);
    chk("loss_clkdiv", clkdiv, 0);
    pll_lock = 1'b1;
    repeat (20) cyc();
    chk("relock_ready", ready, 1);
    chk("relock_flag", lock_lost, 1);
    lock_clr = 1'b1; cyc(); lock_clr = 1'b0;
    chk("clr_flag", lock_lost, 0);
    lock_clr = 1'b1; pll_lock = 1'b0;
    cyc(); cyc(); cyc();
    chk("set_clr_flag", lock_lost, 1);
    cyc();
    chk("clr_after_set", lock_lost, 0);
    lock_clr = 1'b0;

    // One-cycle lock glitch during qualification restarts the count.
    repeat (3) cyc();
    pll_lock = 1'b1;
    repeat (10) cyc();
    pll_lock = 1'b0;
    cyc();
    pll_lock = 1'b1;
    repeat (18) cyc();
    chk("glitch_pre", ready, 0);
    cyc();
    chk("glitch_ready", ready, 1);
    chk("glitch_flag", lock_lost, 0);

    // Async reset in RUN with an update pending on ch0 (D=255, far from wrap).
    repeat (4) cyc();
    cfg_write(0, 7);
    cyc();
    chk("pend_before_rst", cfg_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst2_ready", ready, 0);
    chk("rst2_ce", ce, 0);
    chk("rst2_clkdiv", clkdiv, 0);
    chk("rst2_cfg_ready", cfg_ready, 1);
    chk("rst2_lock_lost", lock_lost, 0);
    model_reset();
    @(negedge clkin);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (18) cyc();
    chk("rst_relock_pre", ready, 0);
    cyc(); chk("rst_relock", ready, 1);
    cyc(); cyc(); chk("rst_div_default_a", ce, 2'b11);
    cyc();        chk("rst_div_default_b", ce, 2'b00);
    cyc();        chk("rst_div_default_c", ce, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
